// File: rtl/ym_seq_pkg.sv
// ym_seq_pkg: shared state encoding, command layout and poll timeout for the YM write sequencer.
package ym_seq_pkg;
  typedef enum logic [2:0] {IDLE, A_SETUP, A_STRB, A_WAIT, D_SETUP, D_STRB, D_WAIT, POLL} state_t;
  localparam int CMD_W = 17;
  localparam int CMD_DATA_LSB = 0;
  localparam int CMD_REG_LSB = 8;
  localparam int CMD_PORT_BIT = 16;
  localparam int POLL_TIMEOUT_CEN = 64;
endpackage

// File: rtl/ym_cmd_fifo.sv
// ym_cmd_fifo: show-ahead synchronous command FIFO with async reset and occupancy output.
module ym_cmd_fifo import ym_seq_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int W = CMD_W
)(
  input  logic                     clk50,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign empty = level == '0;
  assign full = level == LW'(DEPTH);
  assign dout = mem[rp];
  always_ff @(posedge clk50)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk50 or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/ym_write_sequencer.sv
// ym_write_sequencer: replays queued {port,reg,data} commands as FM-core address/data write pairs timed in cen ticks.
// Define BUSY_POLL_EN to poll the status busy flag after each data write (with timeout_err on expiry).
module ym_write_sequencer import ym_seq_pkg::*; #(
  parameter int FIFO_DEPTH = 16,
  parameter int STROBE_CEN = 2,
  parameter int ADDR_WAIT_CEN = 17,
  parameter int DATA_WAIT_CEN = 83
)(
  input  logic                          clk50,
  input  logic                          rst,
  input  logic                          cen,
  input  logic                          cmd_valid,
  input  logic                          cmd_port,
  input  logic [7:0]                    cmd_reg,
  input  logic [7:0]                    cmd_data,
  output logic                          cmd_ready,
  output logic [7:0]                    ym_din,
  output logic [1:0]                    ym_addr,
  output logic                          ym_cs_n,
  output logic                          ym_wr_n,
  input  logic [7:0]                    ym_dout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          timeout_err
);
  state_t state;
  logic [7:0] cnt, lim, cur_data;
  logic [CMD_W-1:0] head;
  logic cur_port, empty, full, pop, hit, unused_dout;
  assign cmd_ready = !rst && !full;
  assign pop = state == IDLE && !empty;
  assign busy = state != IDLE || !empty;
  assign hit = cen && cnt == lim;
  assign unused_dout = ^ym_dout;
  ym_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk50(clk50),
    .rst(rst),
    .push(cmd_valid && cmd_ready),
    .din({cmd_port, cmd_reg, cmd_data}),
    .pop(pop),
    .dout(head),
    .empty(empty),
    .full(full),
    .level(fifo_level)
  );
  always_comb
    lim = (state == A_STRB || state == D_STRB) ? 8'(STROBE_CEN - 1) :
          state == A_WAIT ? 8'(ADDR_WAIT_CEN - 1) :
          state == D_WAIT ? 8'(DATA_WAIT_CEN - 1) : 8'(POLL_TIMEOUT_CEN - 1);
  // cnt free-runs on cen and is zeroed on every hit or SETUP, so each timed state starts from 0
  always_ff @(posedge clk50 or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cur_port <= 1'b0;
      cur_data <= '0;
      ym_din <= '0;
      ym_addr <= '0;
      ym_cs_n <= 1'b1;
      ym_wr_n <= 1'b1;
    end else begin
      if (cen) cnt <= hit ? '0 : cnt + 8'd1;
      case (state)
        IDLE: if (!empty) begin
          state <= A_SETUP;
          ym_addr <= {head[CMD_PORT_BIT], 1'b0};
          ym_din <= head[CMD_REG_LSB +: 8];
          ym_cs_n <= 1'b0;
          cur_port <= head[CMD_PORT_BIT];
          cur_data <= head[CMD_DATA_LSB +: 8];
        end
        A_SETUP, D_SETUP: begin
          state <= state == A_SETUP ? A_STRB : D_STRB;
          ym_wr_n <= 1'b0;
          cnt <= '0;
        end
        A_STRB, D_STRB: if (hit) begin
          state <= state == A_STRB ? A_WAIT : D_WAIT;
          ym_wr_n <= 1'b1;
          ym_cs_n <= 1'b1;
        end
        A_WAIT: if (hit) begin
          state <= D_SETUP;
          ym_addr <= {cur_port, 1'b1};
          ym_din <= cur_data;
          ym_cs_n <= 1'b0;
        end
`ifdef BUSY_POLL_EN
        D_WAIT: if (hit) begin
          state <= POLL;
          ym_addr <= '0;
          ym_cs_n <= 1'b0;
        end
        POLL: if (cen && (!ym_dout[7] || hit)) begin
          state <= IDLE;
          ym_cs_n <= 1'b1;
        end
`else
        D_WAIT: if (hit) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
`ifdef BUSY_POLL_EN
  always_ff @(posedge clk50 or posedge rst)
    if (rst) timeout_err <= 1'b0;
    else timeout_err <= timeout_err || (state == POLL && hit && ym_dout[7]);
`else
  assign timeout_err = 1'b0;
`endif
endmodule
